// File: rtl/mod_down_counter_load_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_down_counter_load_pkg
// Description : Shared timing package: state encoding for the loadable
//               down-counter and default sizing used by tick generators.
// Revision    : 1.0 - initial release
// ============================================================================
package mod_down_counter_load_pkg;

  // Default sizing for tick generators built from this counter.
  localparam int c_DEFAULT_WIDTH = 4;
  localparam int c_DEFAULT_LOAD  = 9;

  // Counter state encoding; 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for the three encodings the state machine can legally occupy.
  function automatic logic state_is_legal(input state_t s);
    return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_DONE);
  endfunction

endpackage : mod_down_counter_load_pkg
`default_nettype wire

// File: rtl/mod_down_counter_load_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_down_counter_load_if
// Description : Control/status bundle of the loadable down-counter. The
//               master (control FSM or register block) drives the strobes
//               and reload value; the slave (the counter) returns count and
//               status.
// Revision    : 1.0 - initial release
// ============================================================================
interface mod_down_counter_load_if #(
  parameter int WIDTH = 4
) ();

  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             busy;
  logic             done;

  // Controller side.
  modport master (
    output enable, load, load_value, start, stop, auto_reload,
    input  Q, tc, busy, done
  );

  // Counter side.
  modport slave (
    input  enable, load, load_value, start, stop, auto_reload,
    output Q, tc, busy, done
  );

endinterface : mod_down_counter_load_if
`default_nettype wire

// File: rtl/mod_down_counter_load.sv
`default_nettype none
// ============================================================================
// Module      : mod_down_counter_load
// Description : Loadable, programmable-modulus down-counter/timer. Counts a
//               loaded value down to zero under an enable strobe, emits a
//               registered one-cycle terminal-count pulse, then either
//               auto-reloads (periodic tick) or parks in DONE (one-shot).
// Revision    : 1.0 - initial release
// ============================================================================
module mod_down_counter_load
  import mod_down_counter_load_pkg::*;
#(
  parameter int WIDTH        = c_DEFAULT_WIDTH,
  parameter int DEFAULT_LOAD = c_DEFAULT_LOAD
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  mod_down_counter_load_if.slave  bus
);

  // A reset value that does not fit the count register is a build error.
  generate
    if ((DEFAULT_LOAD < 0) || (DEFAULT_LOAD >= (2 ** WIDTH))) begin : g_bad_default_load
      $fatal(1, "mod_down_counter_load: DEFAULT_LOAD=%0d does not fit in WIDTH=%0d",
             DEFAULT_LOAD, WIDTH);
    end
  endgenerate

  localparam logic [WIDTH-1:0] c_LOAD_INIT = WIDTH'(DEFAULT_LOAD);
  localparam logic [WIDTH-1:0] c_ZERO      = '0;
  localparam logic [WIDTH-1:0] c_ONE       = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_tc_nxt;
  logic             w_at_zero;

  assign w_at_zero = (r_q == c_ZERO);

  // Next-state / next-count decode, in priority order load > stop > start > count.
  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;

    if (bus.load) begin
      // A load discards whatever count was in flight and parks in IDLE.
      w_reload_nxt = bus.load_value;
      w_q_nxt      = bus.load_value;
      w_state_nxt  = ST_IDLE;
    end else if (!state_is_legal(r_state)) begin
      // Unused encoding: fall back to IDLE keeping the held count.
      w_state_nxt = ST_IDLE;
    end else if (bus.stop && (r_state != ST_IDLE)) begin
      // Abort from RUN or DONE; the count is frozen where it stood.
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Resume from the held count, no reload.
          if (bus.start) begin
            w_state_nxt = ST_RUN;
          end
        end

        ST_DONE: begin
          // Restarting an expired one-shot re-arms from the reload register.
          if (bus.start) begin
            w_q_nxt     = r_reload;
            w_state_nxt = ST_RUN;
          end
        end

        ST_RUN: begin
          // start is ignored while running; only the enable strobe matters.
          if (bus.enable) begin
            if (!w_at_zero) begin
              w_q_nxt = r_q - c_ONE;
            end else begin
              // Zero is consumed this cycle: pulse tc, then reload or expire.
              w_tc_nxt = 1'b1;
              if (bus.auto_reload) begin
                w_q_nxt = r_reload;
              end else begin
                w_state_nxt = ST_DONE;
              end
            end
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_q      <= c_LOAD_INIT;
      r_reload <= c_LOAD_INIT;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
    end
  end

  // Status decodes straight from the state register, so they never glitch.
  assign bus.Q    = r_q;
  assign bus.tc   = r_tc;
  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = (r_state == ST_DONE);

endmodule : mod_down_counter_load
`default_nettype wire

// File: tb/tb_mod_down_counter_load.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_down_counter_load
// Description : Self-checking bench for mod_down_counter_load. Each driven
//               cycle pushes the expected {Q,tc,busy,done} into a scoreboard
//               queue; the word is popped and compared after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_down_counter_load;

  localparam int W = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  mod_down_counter_load_if #(.WIDTH(W)) bus_if ();

  mod_down_counter_load #(
    .WIDTH        (W),
    .DEFAULT_LOAD (9)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard of expected {Q[3:0], tc, busy, done}.
  logic [6:0] sb_q [$];

  // Reference model state: 0=IDLE 1=RUN 2=DONE.
  int         m_st;
  logic [3:0] m_q;
  logic [3:0] m_rl;
  logic       m_tc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    m_q  = 4'd9;
    m_rl = 4'd9;
    m_tc = 1'b0;
  endtask

  // Behaviour of one rising edge as described for the timer.
  task automatic model_edge(input logic en, input logic ld, input logic [3:0] lv,
                            input logic st, input logic sp, input logic ar);
    logic tc_n;
    tc_n = 1'b0;
    if (ld) begin
      m_rl = lv;
      m_q  = lv;
      m_st = 0;
    end else if (sp && m_st != 0) begin
      m_st = 0;
    end else if (st && m_st == 0) begin
      m_st = 1;
    end else if (st && m_st == 2) begin
      m_q  = m_rl;
      m_st = 1;
    end else if (m_st == 1 && en) begin
      if (m_q != 4'd0) begin
        m_q = m_q - 4'd1;
      end else begin
        tc_n = 1'b1;
        if (ar) m_q = m_rl;
        else    m_st = 2;
      end
    end
    m_tc = tc_n;
  endtask

  function automatic logic [6:0] model_word();
    return {m_q, m_tc, (m_st == 1), (m_st == 2)};
  endfunction

  // Drive one cycle of inputs, predict, then compare after the edge.
  task automatic step(input logic en, input logic ld, input logic [3:0] lv,
                      input logic st, input logic sp, input logic ar);
    logic [6:0] exp_w;
    bus_if.enable      = en;
    bus_if.load        = ld;
    bus_if.load_value  = lv;
    bus_if.start       = st;
    bus_if.stop        = sp;
    bus_if.auto_reload = ar;
    model_edge(en, ld, lv, st, sp, ar);
    sb_q.push_back(model_word());
    @(posedge clk);
    #1;
    exp_w = sb_q.pop_front();
    check("cyc", {bus_if.Q, bus_if.tc, bus_if.busy, bus_if.done}, exp_w);
  endtask

  // Enabled cycles until tc appears, bounded by limit.
  task automatic run_to_tc(input logic ar, input int limit, output int lat);
    lat = 0;
    while (lat < limit) begin
      step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, ar);
      lat++;
      if (bus_if.tc === 1'b1) break;
    end
  endtask

  // n enabled cycles, counting tc pulses.
  task automatic run_count(input int n, input logic ar, output int tcs);
    tcs = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, ar);
      if (bus_if.tc === 1'b1) tcs++;
    end
  endtask

  initial begin
    int lat;
    int tcs;
    int tc_off;

    bus_if.enable      = 1'b0;
    bus_if.load        = 1'b0;
    bus_if.load_value  = 4'd0;
    bus_if.start       = 1'b0;
    bus_if.stop        = 1'b0;
    bus_if.auto_reload = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #3;
    check("rst_q",    bus_if.Q,    9);
    check("rst_tc",   bus_if.tc,   0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // One-shot from the default reload of 9.
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("start_busy", bus_if.busy, 1);
    run_to_tc(1'b0, 40, lat);
    check("oneshot_lat", lat, 10);
    check("oneshot_done", bus_if.done, 1);
    check("oneshot_busy", bus_if.busy, 0);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("done_hold_q", bus_if.Q, 0);
    check("done_tc_once", bus_if.tc, 0);

    // Periodic mode, R=3: tc every 4 cycles.
    step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    check("load3_q", bus_if.Q, 3);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    run_count(12, 1'b1, tcs);
    check("periodic_tcs", tcs, 3);
    check("periodic_busy", bus_if.busy, 1);

    // Alternating enable, R=3: tc every 8 cycles, never after a disabled cycle.
    step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    tcs = 0;
    tc_off = 0;
    for (int i = 0; i < 16; i++) begin
      step((i % 2) == 0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      if (bus_if.tc === 1'b1) begin
        tcs++;
        if ((i % 2) != 0) tc_off++;
      end
    end
    check("toggle_tcs", tcs, 2);
    check("toggle_tc_off", tc_off, 0);

    // Stop at Q=5, then resume without reload.
    step(1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("pre_stop_q", bus_if.Q, 5);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    check("stop_q", bus_if.Q, 5);
    check("stop_busy", bus_if.busy, 0);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("resume_q", bus_if.Q, 5);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("resume_dec", bus_if.Q, 4);
    // start while running is ignored; count still steps.
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check("start_in_run", bus_if.Q, 3);

    // load + stop + start together: load wins.
    step(1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    check("ld_win_q", bus_if.Q, 2);
    check("ld_win_busy", bus_if.busy, 0);
    check("ld_win_tc", bus_if.tc, 0);

    // R=0 periodic: tc every enabled cycle, Q stays 0.
    step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    run_count(5, 1'b1, tcs);
    check("r0_tcs", tcs, 5);
    check("r0_q", bus_if.Q, 0);

    // R=0 one-shot: first enabled cycle expires.
    step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("r0_os_done", bus_if.done, 1);
    check("r0_os_tc", bus_if.tc, 1);

    // Full-range reload of 15.
    step(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    run_to_tc(1'b0, 40, lat);
    check("r15_lat", lat, 16);

    // Async reset mid-count at Q=6 after loading 12.
    step(1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_q", bus_if.Q, 6);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("arst_q",    bus_if.Q,    9);
    check("arst_tc",   bus_if.tc,   0);
    check("arst_busy", bus_if.busy, 0);
    check("arst_done", bus_if.done, 0);
    #1;
    reset_n = 1'b1;
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    run_to_tc(1'b0, 40, lat);
    check("post_rst_lat", lat, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mod_down_counter_load
`default_nettype wire

// File: doc/mod_down_counter_load.md
Name: mod_down_counter_load

Overview:
Loadable, programmable modulus down-counter/timer that complements the team's free-running mod-N up-counter. It counts from a software-loaded value down to zero under an enable strobe and emits a one-cycle terminal-count pulse. It either auto-reloads for periodic ticks or stops in DONE for one-shot delays. It sits next to the up-counters in timing/tick-generation logic and is driven by a control FSM or register block.

Parameters:
WIDTH, 4, bit width of count, load value and Q
DEFAULT_LOAD, 9, reload value after reset; must satisfy DEFAULT_LOAD < 2**WIDTH (elaboration-time check, fatal if violated)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  count strobe; counter advances only when high
load  input  1  load reload register and Q from load_value
load_value  input  WIDTH  new reload value, sampled when load=1
start  input  1  begin/restart counting
stop  input  1  abort counting, return to IDLE
auto_reload  input  1  1: periodic mode; 0: one-shot mode; sampled at each zero crossing
Q  output  WIDTH  current count
tc  output  1  registered one-cycle terminal-count pulse
busy  output  1  high while state==RUN
done  output  1  high while state==DONE

Behaviour:
- Clock clk, reset reset_n asynchronous active-low.
- States:
  - IDLE: holds Q.
  - RUN: counts.
  - DONE: one-shot expired, Q=0.
- Reset values:
  - state=IDLE, Q=DEFAULT_LOAD, reload_reg=DEFAULT_LOAD.
  - tc=0, busy=0, done=0.
- Per-cycle priority: reset > load > stop > start > count.
- load=1, any state:
  - reload_reg<=load_value, Q<=load_value, state<=IDLE.
  - Any in-progress count is discarded; tc<=0.
- stop=1 (no load):
  - From RUN or DONE: state<=IDLE, Q holds.
  - In IDLE: no effect.
- start=1 (no load/stop):
  - From IDLE: state<=RUN, Q unchanged, so counting resumes from the held value.
  - From DONE: Q<=reload_reg, state<=RUN.
  - In RUN: ignored. No restart, and the count step still happens that cycle.
- RUN with enable=1:
  - Q!=0: Q<=Q-1.
  - Q==0 and auto_reload=1: Q<=reload_reg, stay RUN, tc<=1.
  - Q==0 and auto_reload=0: stay Q=0, state<=DONE, tc<=1.
- Period: reload value R with enable held high gives one tc every R+1 cycles. Latency from start (from DONE, or IDLE with Q=R) to tc high is R+1 cycles after the start edge.
- RUN with enable=0: Q and state hold, tc<=0.
- tc is high exactly one cycle per zero crossing, registered (asserted the cycle after Q==0 is consumed). It is 0 in all other cycles.
- busy and done decode state combinationally from registered state, so they are glitch-free relative to clk.
- Boundaries:
  - R=0 with auto_reload=1: tc high every enabled cycle, Q stays 0.
  - R=0 with auto_reload=0: first enabled RUN cycle goes to DONE.
  - R=2**WIDTH-1 is legal (full range).
  - Q never underflows; there is no wrap below 0.
- Async reset asserted mid-count: all state returns to reset values immediately. reload_reg reverts to DEFAULT_LOAD and the loaded value is lost.

Decomposition:
- Shared timing package holds:
  - State encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 illegal, recovers to IDLE).
  - Default WIDTH/DEFAULT_LOAD constants used by tick generators.
- Single module, no sub-module.
- Internal structure: state register, datapath registers (Q, reload_reg, tc), next-state/next-Q combinational block.

Test Plan:
- Reset release, WIDTH=4, DEFAULT_LOAD=9, start=1 one cycle, enable=1, auto_reload=0 -> Q goes 9,8,...,0. tc high one cycle 10 cycles after start; done=1, busy=0, Q holds 0.
- load=1, load_value=3, then start, enable=1, auto_reload=1 -> Q 3,2,1,0,3,2,...; tc every 4 cycles; busy stays 1.
- enable toggled 1/0 alternately, R=3, auto_reload=1 -> Q changes only on enabled cycles; tc every 8 cycles; no tc during enable=0 cycles.
- At Q=5 in RUN, assert stop -> state IDLE, Q=5 held. Then start -> resumes 4,3,... with no reload.
- Same cycle load=1 (value 2), stop=1, start=1 during RUN -> load wins: Q=2, IDLE, tc=0. load_value=0 with auto_reload=1 then start -> tc high every cycle.
- Assert reset_n low asynchronously mid-count at Q=6 after load of 12 -> Q=9 immediately, tc=0, busy=0, done=0. reload_reg=9 confirmed by running a one-shot (10 cycles to tc).
